// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: execute-stage result handshake into the write-back sequencer
interface regfile_writeback_if #(parameter int DW = 8, parameter int AW = 3);
  logic          RES_VALID;
  logic          RES_READY;
  logic [AW-1:0] RES_DSEL;
  logic [DW-1:0] RES_DATA;
  modport master (output RES_VALID, RES_DSEL, RES_DATA, input RES_READY);
  modport slave  (input RES_VALID, RES_DSEL, RES_DATA, output RES_READY);
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: buffers results in a FIFO, retires one register write per cycle, tracks pending writes
module regfile_writeback #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  regfile_writeback_if.slave       res,
  input  logic                     ISSUE,
  input  logic [AW-1:0]            ISSUE_DSEL,
  output logic [AW-1:0]            DSEL,
  output logic [DW-1:0]            RIN,
  output logic [2**AW-1:0]         BUSY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     ERR
);
  localparam int NR  = 2**AW;
  localparam int PTR = $clog2(DEPTH);
  localparam int CW  = PTR + 1;
  logic [AW-1:0]  dsel_mem [DEPTH];
  logic [DW-1:0]  data_mem [DEPTH];
  logic [PTR-1:0] wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic [AW-1:0]  dsel_q;
  logic [DW-1:0]  rin_q;
  logic [PW-1:0]  pend_q [NR];
  logic [PW-1:0]  pend_d [NR];
  logic           ovf [NR];
  logic           err_q, err_d;
  logic           push, pop;
  // Destination 0 is swallowed at the handshake so it never occupies a slot.
  assign res.RES_READY = !RST && cnt_q < CW'(DEPTH);
  assign push  = res.RES_VALID && res.RES_READY && res.RES_DSEL != '0;
  assign pop   = cnt_q != '0;
  assign DSEL  = dsel_q;
  assign RIN   = rin_q;
  assign COUNT = cnt_q;
  assign ERR   = err_q;
  assign pend_d[0] = '0;
  assign ovf[0]    = 1'b0;
  // A retire coinciding with an issue cancels out; a saturated counter ignores the issue and flags overflow.
  for (genvar r = 1; r < NR; r++) begin : g_pend
    logic inc, dec, sat;
    assign inc = ISSUE && ISSUE_DSEL == AW'(r);
    assign dec = dsel_q == AW'(r);
    assign sat = &pend_q[r];
    assign ovf[r] = inc && !dec && sat;
    assign pend_d[r] = inc == dec ? pend_q[r] :
                       inc        ? (sat ? pend_q[r] : pend_q[r] + 1'b1) :
                       pend_q[r] != '0 ? pend_q[r] - 1'b1 : pend_q[r];
  end
  // Busy flags come straight from the registered counters; overflow is folded into the sticky error.
  always_comb begin
    BUSY  = '0;
    err_d = err_q;
    for (int r = 1; r < NR; r++) begin
      BUSY[r] = pend_q[r] != '0;
      err_d   = err_d | ovf[r];
    end
  end
  // FIFO storage needs no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) begin
      dsel_mem[wr_q] <= res.RES_DSEL;
      data_mem[wr_q] <= res.RES_DATA;
    end
  end
  // Pointers, occupancy, write-port registers and scoreboard state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dsel_q <= '0;
      rin_q  <= '0;
      pend_q <= '{default: '0};
      err_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        dsel_q <= dsel_mem[rd_q];
        rin_q  <= data_mem[rd_q];
        rd_q   <= rd_q + 1'b1;
      end else begin
        dsel_q <= '0;
      end
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
endmodule
